alu_arbiter: RTL

- Shares one 32-bit ALU execution resource between two requesters. Logic ops (AND, OR) and arithmetic ops (ADD, SUB) complete in one cycle; an unsigned multiply runs iteratively.
- Every result uses the codebase's split 64-bit format: res_high holds the upper word, res_low the lower word. res_high is zero for logic ops.
- Sits between the two issue ports and the register-file writeback.
- Handles round-robin arbitration, op sequencing, and a one-entry result hold with backpressure.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/mul_iter.sv | 83 ++++++++
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and counter-sizing definitions for the ALU arbiter slice.
package alu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
   localparam logic [OP_W-1:0] OP_MULU = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // One extra bit so the counter can hold the full cycle count itself.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier, LSB first, one multiplier bit per cycle.
module mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                               input logic [WIDTH-1:0]   m,
                                               input logic               bit0);
      logic [WIDTH:0] upper;
      upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (bit0 ? {1'b0, m} : '0);
      return {upper, p[WIDTH-1:1]};
   endfunction

   // The first step is folded into the start edge, so the product is final
   // one cycle before the owner's WIDTH-cycle window closes.
   always_comb begin
      a_d     = a_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      if (start) begin
         a_d     = a;
         mcand_d = b >> 1;
         prod_d  = step('0, a, b[0]);
         cnt_d   = CW'(WIDTH - 1);
         busy_d  = 1'b1;
         done_d  = 1'b0;
      end else if (busy_q) begin
         prod_d  = step(prod_q, a_q, mcand_q[0]);
         mcand_d = mcand_q >> 1;
         cnt_d   = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q     <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end to a shared ALU with an iterative multiplier
// and a one-entry result hold released by rsp_ready.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic              rsp_err,
   output logic [WIDTH-1:0]  res_high,
   output logic [WIDTH-1:0]  res_low
);

   localparam int CW = cnt_width(MUL_CYCLES);

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rsp_id_q, rsp_id_d;
   logic              rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0]  res_hi_q, res_hi_d;
   logic [WIDTH-1:0]  res_lo_q, res_lo_d;

   logic              grant;
   logic              accept;
   logic [OP_W-1:0]   sel_op;
   logic [WIDTH-1:0]  sel_a, sel_b;
   logic [WIDTH-1:0]  alu_hi, alu_lo;
   logic              alu_err;
   logic [WIDTH:0]    sum;

   logic              mul_start;
   logic              mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;

   always_comb begin
      case ({req1_valid, req0_valid})
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant_q;
         default: grant = 1'b0;
      endcase
   end

   assign accept     = reset_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept && (grant == 1'b0) && req0_valid;
   assign req1_ready = accept && (grant == 1'b1) && req1_valid;

   assign sel_op = grant ? req1_op : req0_op;
   assign sel_a  = grant ? req1_a  : req0_a;
   assign sel_b  = grant ? req1_b  : req0_b;

   always_comb begin
      alu_hi  = '0;
      alu_lo  = '0;
      alu_err = 1'b0;
      sum     = {1'b0, sel_a} + {1'b0, sel_b};
      case (sel_op)
         OP_AND:  alu_lo = sel_a & sel_b;
         OP_OR:   alu_lo = sel_a | sel_b;
         OP_ADD: begin
            alu_lo = sum[WIDTH-1:0];
            alu_hi = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
         end
         OP_SUB: begin
            alu_lo = sel_a - sel_b;
            alu_hi = (sel_a < sel_b) ? '1 : '0;
         end
         OP_MULU: alu_err = 1'b0;
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      rsp_id_d     = rsp_id_q;
      rsp_err_d    = rsp_err_q;
      res_hi_d     = res_hi_q;
      res_lo_d     = res_lo_q;
      mul_start    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               last_grant_d = grant;
               rsp_id_d     = grant;
               if (sel_op == OP_MULU) begin
                  mul_start = 1'b1;
                  cnt_d     = CW'(MUL_CYCLES);
                  rsp_err_d = 1'b0;
                  state_d   = ST_EXEC;
               end else begin
                  rsp_err_d = alu_err;
                  res_hi_d  = alu_hi;
                  res_lo_d  = alu_lo;
                  state_d   = ST_RESP;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) begin
               res_hi_d = mul_product[2*WIDTH-1:WIDTH];
               res_lo_d = mul_product[WIDTH-1:0];
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         rsp_id_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
         res_hi_q     <= '0;
         res_lo_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         rsp_id_q     <= rsp_id_d;
         rsp_err_q    <= rsp_err_d;
         res_hi_q     <= res_hi_d;
         res_lo_q     <= res_lo_d;
      end
   end

   mul_iter #(
      .WIDTH   (WIDTH)
   ) u_mul (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (sel_a),
      .b       (sel_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;
   assign res_high  = res_hi_q;
   assign res_low   = res_lo_q;

   // Requesters must hold valid until accepted; the multiplier must be
   // finished by the time the EXEC window closes.
   a_req0_hold: assert property (@(posedge clock) disable iff (!reset_n)
      (req0_valid && !req0_ready) |=> req0_valid);
   a_req1_hold: assert property (@(posedge clock) disable iff (!reset_n)
      (req1_valid && !req1_ready) |=> req1_valid);
   a_mul_start: assert property (@(posedge clock) disable iff (!reset_n)
      mul_start |=> mul_busy);
   a_mul_done: assert property (@(posedge clock) disable iff (!reset_n)
      (state_q == ST_EXEC && cnt_q == CW'(1)) |-> mul_done);

endmodule
